etapa_wb: RTL and testbench
===========================

# etapa_wb

Write-back stage of the vector processor pipeline, and the write-port partner of the decode/register-read stage. It accepts completed results from the execute/memory side through a valid/ready handshake and buffers them in a small in-order FIFO. It then drives the shared register-file write port (`data_wrv`, `data_wrs`, `i_dir_wr`, `reg_wrv`, `reg_wrs`) one write per cycle. It also publishes per-register pending bitmaps so decode can interlock on outstanding writes.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, at least 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: the upstream result is valid.
- `in_ready` out 1: the block can accept; equals `count < DEPTH`.
- `in_kind` in 2: result kind.
  - 00: none.
  - 01: vector only.
  - 10: scalar only.
  - 11: vector then scalar.
- `in_dir_v` in 3: vector destination register.
- `in_dir_s` in 3: scalar destination register.
- `in_vec` in 32: vector result, 4 lanes × 8 bits, lane 0 in [7:0].
- `in_sca` in 8: scalar result.
- `data_wrv` out 32: vector write data.
- `data_wrs` out 8: scalar write data.
- `i_dir_wr` out 3: write address shared by both banks.
- `reg_wrv` out 1: vector bank write strobe.
- `reg_wrs` out 1: scalar bank write strobe.
- `pend_v` out 8: bit r = 1 while a vector write to r is outstanding.
- `pend_s` out 8: bit r = 1 while a scalar write to r is outstanding.
- `count` out clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: FIFO non-empty or a strobe is active.

## Operation
- Accept rule: an accept happens on a rising edge where `in_valid && in_ready`.
  - Kind 01/10/11 is pushed as {kind, dir_v, dir_s, vec, sca}.
  - Kind 00 is consumed with no push and no write.
- The FIFO is first-word-fall-through. The head is visible in the cycle after its push.
- FSM states: IDLE, WR_V, WR_S. The state register drives the registered output stage.
  - IDLE, head empty: stay in IDLE.
  - IDLE or completing any write, head kind 01: go to WR_V and pop the head.
  - Same condition, head kind 10: go to WR_S and pop the head.
  - Same condition, head kind 11: go to WR_V without popping.
  - WR_V of a kind-11 entry: go to WR_S and pop the head.
  - When a write completes and the FIFO is empty, go to IDLE.
- Outputs per state:
  - WR_V: `reg_wrv`=1, `i_dir_wr`=dir_v, `data_wrv`=vec.
  - WR_S: `reg_wrs`=1, `i_dir_wr`=dir_s, `data_wrs`=sca.
  - `reg_wrv` and `reg_wrs` are never both 1.
- Data and address outputs are 0 whenever their strobe is 0. `i_dir_wr` is 0 in IDLE.
- Throughput: one register write per cycle, so a kind-11 entry occupies two write cycles. Writes retire strictly in acceptance order.
- Pending bitmaps:
  - `pend_v` is the combinational OR of dir_v over FIFO entries of kind 01/11, plus the current WR_V output; `pend_s` is formed the same way from dir_s.
  - For kind 11, `pend_s` stays set through the WR_S cycle.
- `count` is incremented on a push, decremented on a pop, and unchanged on a simultaneous push and pop. Pointers wrap modulo DEPTH.
- `in_ready` depends only on `count`. A full FIFO does not accept in the same cycle it pops; the slot frees in the next cycle.

## Timing
- Reset values: `in_ready`=1, all other outputs 0, state IDLE, FIFO empty, pointers 0.
- Reset is asynchronous. Assertion mid-operation drops strobes without waiting for a clock edge, discards all FIFO entries, and any pending WR_S is never issued.
- Latency: an entry accepted at edge E0 into an idle, empty block has its first strobe high from E1 to E2. For kind 11, WR_S is high from E2 to E3.
- A pending bit is set in the cycle after the accept edge. It clears in the cycle after the edge that ends that register's strobe.
- Same-cycle register-file write and read semantics belong to the register file, not this block.

## Test plan
- Reset: assert `reset` with `in_valid`=1 → all outputs 0, `in_ready`=1, `pend_v`=`pend_s`=0, `count`=0; nothing accepted.
- Vector write: kind 01, dir_v 5, vec 0xDEADBEEF accepted at E0.
  - `reg_wrv`=1, `i_dir_wr`=5, `data_wrv`=0xDEADBEEF for exactly one cycle after E1.
  - `pend_v`=0x20 after E0, 0x00 after E2.
- Dual write: kind 11, dir_v 2, dir_s 6, vec 0x04030201, sca 0x7F.
  - WR_V (addr 2, 0x04030201), then WR_S (addr 6, 0x7F) on consecutive cycles.
  - `pend_s`[6] stays set through the WR_S cycle.
- Back-pressure: drive three kind-11 entries back-to-back with DEPTH=2.
  - `in_ready` falls when `count`=2 and the third entry is held.
  - All six writes appear in order with no gaps and no loss.
- Null kind: kind 00 accepted → no strobe, `count` and pend bitmaps unchanged.
- Async reset: assert `reset` mid-cycle while in the WR_V cycle of a kind-11 entry.
  - `reg_wrv` drops before the next edge, and WR_S never appears.
  - `count`=0 and `busy`=0.

Source files
------------

// File: rtl/etapa_wb.sv
// Write-back stage: in-order result FIFO feeding the shared register-file write port, with pending bitmaps for decode.
// Latency: accept at edge E0 into an idle, empty block gives the first strobe from E1 to E2; kind 11 adds WR_S from E2 to E3.
// Backpressure: in_ready = (count < DEPTH); a full FIFO frees its slot only in the cycle after a pop.
module etapa_wb #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_kind,
   input  logic [2:0]               in_dir_v,
   input  logic [2:0]               in_dir_s,
   input  logic [31:0]              in_vec,
   input  logic [7:0]               in_sca,
   output logic [31:0]              data_wrv,
   output logic [7:0]               data_wrs,
   output logic [2:0]               i_dir_wr,
   output logic                     reg_wrv,
   output logic                     reg_wrs,
   output logic [7:0]               pend_v,
   output logic [7:0]               pend_s,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   // kind[0] marks a vector write, kind[1] a scalar write
   typedef struct packed {
      logic [1:0]  kind;
      logic [2:0]  dir_v;
      logic [2:0]  dir_s;
      logic [31:0] vec;
      logic [7:0]  sca;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR_V = 2'd1,
      S_WR_S = 2'd2
   } state_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   state_t          state_q, state_d;
   entry_t          cur_q, cur_d;
   entry_t          head;
   logic            empty;
   logic            push;
   logic            pop;
   logic            load;
   logic [PW-1:0]   slot;

   assign in_ready = (count_q < CW'(DEPTH));
   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign head     = mem_q[rd_ptr_q];
   // kind 00 completes the handshake but never occupies a slot
   assign push     = in_valid && in_ready && (in_kind != 2'b00);

   // FIFO storage; contents beyond the occupancy window are never observed, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_kind, in_dir_v, in_dir_s, in_vec, in_sca};
      end
   end

   // Pointer and occupancy next-state; simultaneous push and pop leaves count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State register plus FIFO pointers and the entry currently being written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cur_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Next-state: a kind-11 entry stays at the head through its WR_V cycle and is popped entering WR_S
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      load    = 1'b0;
      if ((state_q == S_WR_V) && (cur_q.kind == 2'b11)) begin
         state_d = S_WR_S;
         pop     = !empty;
      end else if (empty) begin
         state_d = S_IDLE;
      end else begin
         load = 1'b1;
         case (head.kind)
            2'b01: begin
               state_d = S_WR_V;
               pop     = 1'b1;
            end
            2'b10: begin
               state_d = S_WR_S;
               pop     = 1'b1;
            end
            2'b11: begin
               state_d = S_WR_V;
            end
            default: begin
               // never stored; drop it rather than wedge the stage
               state_d = S_IDLE;
               pop     = 1'b1;
               load    = 1'b0;
            end
         endcase
      end
      cur_d = load ? head : cur_q;
   end

   // Register-file write port driven purely from the registered state and current entry
   always_comb begin
      reg_wrv  = 1'b0;
      reg_wrs  = 1'b0;
      data_wrv = '0;
      data_wrs = '0;
      i_dir_wr = '0;
      case (state_q)
         S_WR_V: begin
            reg_wrv  = 1'b1;
            data_wrv = cur_q.vec;
            i_dir_wr = cur_q.dir_v;
         end
         S_WR_S: begin
            reg_wrs  = 1'b1;
            data_wrs = cur_q.sca;
            i_dir_wr = cur_q.dir_s;
         end
         default: begin
            reg_wrv = 1'b0;
         end
      endcase
      busy = !empty || (state_q != S_IDLE);
   end

   // Pending bitmaps: every occupied FIFO slot plus the write currently on the port
   always_comb begin
      pend_v = '0;
      pend_s = '0;
      slot   = rd_ptr_q;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rd_ptr_q + PW'(k);
         if (CW'(k) < count_q) begin
            if (mem_q[slot].kind[0]) pend_v[mem_q[slot].dir_v] = 1'b1;
            if (mem_q[slot].kind[1]) pend_s[mem_q[slot].dir_s] = 1'b1;
         end
      end
      if (state_q == S_WR_V) pend_v[cur_q.dir_v] = 1'b1;
      if (state_q == S_WR_S) pend_s[cur_q.dir_s] = 1'b1;
   end

endmodule

// File: tb/tb_etapa_wb.sv
// Bench for etapa_wb: scoreboard of expected register writes versus writes seen on the port.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Each scenario task compares its own observations inline.
module tb_etapa_wb;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_kind = 2'b00;
   logic [2:0]  in_dir_v = 3'd0;
   logic [2:0]  in_dir_s = 3'd0;
   logic [31:0] in_vec = 32'h0;
   logic [7:0]  in_sca = 8'h0;
   logic [31:0] data_wrv;
   logic [7:0]  data_wrs;
   logic [2:0]  i_dir_wr;
   logic        reg_wrv;
   logic        reg_wrs;
   logic [7:0]  pend_v;
   logic [7:0]  pend_s;
   logic [$clog2(DEPTH):0] count;
   logic        busy;

   typedef struct {
      logic        is_v;
      logic [2:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_err = 0;

   always #5 clk = ~clk;

   etapa_wb #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_kind  (in_kind),
      .in_dir_v (in_dir_v),
      .in_dir_s (in_dir_s),
      .in_vec   (in_vec),
      .in_sca   (in_sca),
      .data_wrv (data_wrv),
      .data_wrs (data_wrs),
      .i_dir_wr (i_dir_wr),
      .reg_wrv  (reg_wrv),
      .reg_wrs  (reg_wrs),
      .pend_v   (pend_v),
      .pend_s   (pend_s),
      .count    (count),
      .busy     (busy)
   );

   // advance one edge and log any write seen on the port
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (reg_wrv === 1'b1)
         obs_q.push_back('{1'b1, i_dir_wr, data_wrv, cyc});
      else if (reg_wrs === 1'b1)
         obs_q.push_back('{1'b0, i_dir_wr, {24'h0, data_wrs}, cyc});
   endtask

   // offer one result, wait for in_ready, take the accepting edge, record expected writes
   task automatic send(input logic [1:0] k, input logic [2:0] dv, input logic [2:0] ds,
                       input logic [31:0] v, input logic [7:0] s);
      int guard;
      in_valid = 1'b1;
      in_kind  = k;
      in_dir_v = dv;
      in_dir_s = ds;
      in_vec   = v;
      in_sca   = s;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 40) begin
         step();
         guard++;
      end
      if (guard >= 40) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready=%b required 1 within 40 cycles", in_ready);
      end
      step();
      if (k[0]) exp_q.push_back('{1'b1, dv, v, 0});
      if (k[1]) exp_q.push_back('{1'b0, ds, {24'h0, s}, 0});
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_kind  = 2'b00;
   endtask

   task automatic test_reset();
      #2;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_kind  = 2'b01;
      in_dir_v = 3'd3;
      in_vec   = 32'h12345678;
      step();
      step();
      n_cmp++;
      if ({reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs} !== 45'h0) begin
         n_err++;
         $display("FAIL reset_port: wrv=%b wrs=%b dir=%0d dv=%h ds=%h required all 0",
                  reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs);
      end
      n_cmp++;
      if (in_ready !== 1'b1 || count !== 2'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: in_ready=%b count=%0d busy=%b required 1/0/0", in_ready, count, busy);
      end
      n_cmp++;
      if (pend_v !== 8'h00 || pend_s !== 8'h00) begin
         n_err++;
         $display("FAIL reset_pend: pend_v=%h pend_s=%h required 00/00", pend_v, pend_s);
      end
      idle();
      reset = 1'b0;
      step();
      n_cmp++;
      if (count !== 2'd0 || busy !== 1'b0 || obs_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_noaccept: count=%0d busy=%b writes=%0d required 0/0/0", count, busy, obs_q.size());
      end
   endtask

   task automatic test_vector();
      send(2'b01, 3'd5, 3'd1, 32'hDEADBEEF, 8'h99);
      idle();
      n_cmp++;
      if (pend_v !== 8'h20 || pend_s !== 8'h00 || count !== 2'd1 || reg_wrv !== 1'b0) begin
         n_err++;
         $display("FAIL vec_e0: pend_v=%h pend_s=%h count=%0d wrv=%b required 20/00/1/0", pend_v, pend_s, count, reg_wrv);
      end
      step();
      n_cmp++;
      if (reg_wrv !== 1'b1 || reg_wrs !== 1'b0 || i_dir_wr !== 3'd5 || data_wrv !== 32'hDEADBEEF || data_wrs !== 8'h00) begin
         n_err++;
         $display("FAIL vec_e1: wrv=%b wrs=%b dir=%0d dv=%h ds=%h required 1/0/5/deadbeef/00",
                  reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs);
      end
      n_cmp++;
      if (pend_v !== 8'h20 || count !== 2'd0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL vec_e1_pend: pend_v=%h count=%0d busy=%b required 20/0/1", pend_v, count, busy);
      end
      step();
      n_cmp++;
      if (reg_wrv !== 1'b0 || pend_v !== 8'h00 || busy !== 1'b0 || i_dir_wr !== 3'd0 || data_wrv !== 32'h0) begin
         n_err++;
         $display("FAIL vec_e2: wrv=%b pend_v=%h busy=%b dir=%0d dv=%h required 0/00/0/0/0",
                  reg_wrv, pend_v, busy, i_dir_wr, data_wrv);
      end
      while (obs_q.size() > 0) begin
         wr_t o;
         wr_t e;
         o = obs_q.pop_front();
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL vec_sb: write v=%b addr=%0d data=%h required none", o.is_v, o.addr, o.data);
         end else begin
            e = exp_q.pop_front();
            if (o.is_v !== e.is_v || o.addr !== e.addr || o.data !== e.data) begin
               n_err++;
               $display("FAIL vec_sb: got v=%b addr=%0d data=%h required v=%b addr=%0d data=%h",
                        o.is_v, o.addr, o.data, e.is_v, e.addr, e.data);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL vec_missing: %0d writes outstanding required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_dual();
      send(2'b11, 3'd2, 3'd6, 32'h04030201, 8'h7F);
      idle();
      n_cmp++;
      if (pend_v !== 8'h04 || pend_s !== 8'h40) begin
         n_err++;
         $display("FAIL dual_e0: pend_v=%h pend_s=%h required 04/40", pend_v, pend_s);
      end
      step();
      n_cmp++;
      if (reg_wrv !== 1'b1 || reg_wrs !== 1'b0 || i_dir_wr !== 3'd2 || data_wrv !== 32'h04030201 || pend_s !== 8'h40) begin
         n_err++;
         $display("FAIL dual_wrv: wrv=%b wrs=%b dir=%0d dv=%h pend_s=%h required 1/0/2/04030201/40",
                  reg_wrv, reg_wrs, i_dir_wr, data_wrv, pend_s);
      end
      step();
      n_cmp++;
      if (reg_wrs !== 1'b1 || reg_wrv !== 1'b0 || i_dir_wr !== 3'd6 || data_wrs !== 8'h7F || data_wrv !== 32'h0) begin
         n_err++;
         $display("FAIL dual_wrs: wrs=%b wrv=%b dir=%0d ds=%h dv=%h required 1/0/6/7f/0",
                  reg_wrs, reg_wrv, i_dir_wr, data_wrs, data_wrv);
      end
      n_cmp++;
      if (pend_s !== 8'h40 || pend_v !== 8'h00) begin
         n_err++;
         $display("FAIL dual_pend_wrs: pend_s=%h pend_v=%h required 40/00", pend_s, pend_v);
      end
      step();
      n_cmp++;
      if (reg_wrs !== 1'b0 || pend_s !== 8'h00 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL dual_end: wrs=%b pend_s=%h busy=%b required 0/00/0", reg_wrs, pend_s, busy);
      end
      while (obs_q.size() > 0) begin
         wr_t o;
         wr_t e;
         o = obs_q.pop_front();
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL dual_sb: write v=%b addr=%0d data=%h required none", o.is_v, o.addr, o.data);
         end else begin
            e = exp_q.pop_front();
            if (o.is_v !== e.is_v || o.addr !== e.addr || o.data !== e.data) begin
               n_err++;
               $display("FAIL dual_sb: got v=%b addr=%0d data=%h required v=%b addr=%0d data=%h",
                        o.is_v, o.addr, o.data, e.is_v, e.addr, e.data);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL dual_missing: %0d writes outstanding required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      int seen;
      send(2'b11, 3'd1, 3'd2, 32'h11111111, 8'hA1);
      send(2'b11, 3'd3, 3'd4, 32'h22222222, 8'hB2);
      n_cmp++;
      if (count !== 2'd2 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_full: count=%0d in_ready=%b required 2/0", count, in_ready);
      end
      send(2'b11, 3'd5, 3'd7, 32'h33333333, 8'hC3);
      idle();
      n_cmp++;
      if (count !== 2'd2 || reg_wrv !== 1'b1) begin
         n_err++;
         $display("FAIL bp_third: count=%0d wrv=%b required 2/1", count, reg_wrv);
      end
      for (int i = 0; i < 5; i++) step();
      n_cmp++;
      if (count !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_drain: count=%0d busy=%b in_ready=%b required 0/0/1", count, busy, in_ready);
      end
      prev = 0;
      seen = 0;
      while (obs_q.size() > 0) begin
         wr_t o;
         wr_t e;
         o = obs_q.pop_front();
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bp_sb: write v=%b addr=%0d data=%h required none", o.is_v, o.addr, o.data);
         end else begin
            e = exp_q.pop_front();
            if (o.is_v !== e.is_v || o.addr !== e.addr || o.data !== e.data) begin
               n_err++;
               $display("FAIL bp_sb: got v=%b addr=%0d data=%h required v=%b addr=%0d data=%h",
                        o.is_v, o.addr, o.data, e.is_v, e.addr, e.data);
            end
         end
         if (seen > 0) begin
            n_cmp++;
            if (o.cyc != prev + 1) begin
               n_err++;
               $display("FAIL bp_gap: write at cycle %0d required cycle %0d", o.cyc, prev + 1);
            end
         end
         prev = o.cyc;
         seen++;
      end
      n_cmp++;
      if (seen != 6 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bp_total: writes=%0d outstanding=%0d required 6/0", seen, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_null();
      send(2'b00, 3'd3, 3'd3, 32'hFFFFFFFF, 8'hFF);
      idle();
      n_cmp++;
      if (count !== 2'd0 || pend_v !== 8'h00 || pend_s !== 8'h00 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL null_e0: count=%0d pend_v=%h pend_s=%h in_ready=%b required 0/00/00/1",
                  count, pend_v, pend_s, in_ready);
      end
      step();
      step();
      n_cmp++;
      if (obs_q.size() != 0 || busy !== 1'b0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL null_nowrite: writes=%0d busy=%b required 0/0", obs_q.size(), busy);
         obs_q.delete();
      end
   endtask

   task automatic test_async_reset();
      send(2'b11, 3'd4, 3'd1, 32'hCAFEF00D, 8'h55);
      idle();
      step();
      n_cmp++;
      if (reg_wrv !== 1'b1 || i_dir_wr !== 3'd4) begin
         n_err++;
         $display("FAIL ar_wrv: wrv=%b dir=%0d required 1/4", reg_wrv, i_dir_wr);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (reg_wrv !== 1'b0 || reg_wrs !== 1'b0 || data_wrv !== 32'h0 || i_dir_wr !== 3'd0) begin
         n_err++;
         $display("FAIL ar_drop: wrv=%b wrs=%b dv=%h dir=%0d required 0/0/0/0", reg_wrv, reg_wrs, data_wrv, i_dir_wr);
      end
      n_cmp++;
      if (count !== 2'd0 || busy !== 1'b0 || pend_v !== 8'h00 || pend_s !== 8'h00 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ar_state: count=%0d busy=%b pend_v=%h pend_s=%h in_ready=%b required 0/0/00/00/1",
                  count, busy, pend_v, pend_s, in_ready);
      end
      while (obs_q.size() > 0) begin
         wr_t o;
         wr_t e;
         o = obs_q.pop_front();
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL ar_sb: write v=%b addr=%0d data=%h required none", o.is_v, o.addr, o.data);
         end else begin
            e = exp_q.pop_front();
            if (o.is_v !== e.is_v || o.addr !== e.addr || o.data !== e.data) begin
               n_err++;
               $display("FAIL ar_sb: got v=%b addr=%0d data=%h required v=%b addr=%0d data=%h",
                        o.is_v, o.addr, o.data, e.is_v, e.addr, e.data);
            end
         end
      end
      // the scalar half of the entry is discarded by the reset
      exp_q.delete();
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (obs_q.size() != 0 || reg_wrs !== 1'b0 || busy !== 1'b0 || count !== 2'd0) begin
         n_err++;
         $display("FAIL ar_nowrs: writes=%0d wrs=%b busy=%b count=%0d required 0/0/0/0",
                  obs_q.size(), reg_wrs, busy, count);
      end
   endtask

   initial begin
      test_reset();
      test_vector();
      test_dual();
      test_back_to_back();
      test_null();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
